if_fetch_buf: RTL and testbench

- Fetch-side buffer between the PC register / instruction ROM and the ID stage.
- Captures each (pc, inst) pair presented while the PC register's chip-enable is high into a small FIFO.
- Hands pairs to decode over a valid/ready handshake.
- Raises a stall request back to the PC register when full, and discards all contents on a pipeline flush (branch/exception).

---
 rtl/if_fetch_buf_pkg.sv | 15 +
 rtl/if_fetch_buf_fifo.sv | 81 ++++++++
 rtl/if_fetch_buf.sv | 86 ++++++++
 tb/tb_if_fetch_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-path definitions: bus widths, zero word, reset levels and buffer depth default.
// Imported by if_fetch_fifo and if_fetch_buf.
package if_fetch_buf_pkg;

    localparam int          InstAddrBus   = 32;
    localparam int          InstBus       = 32;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;

    // Active-high reset level of the core; the fetch buffer uses the active-low one.
    localparam logic        RstEnable     = 1'b1;
    localparam logic        RstnEnable    = 1'b0;

    localparam int          FetchBufDepth = 4;

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Generic (pc, inst) storage ring with write/read pointers and occupancy count.
// Clear has priority over push and pop; the caller never pushes when full or pops when empty.
module if_fetch_fifo
    import if_fetch_buf_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus,
    parameter int DEPTH  = FetchBufDepth,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] wr_pc_i,
    input  logic [DATA_W-1:0] wr_inst_i,
    output logic [ADDR_W-1:0] rd_pc_o,
    output logic [DATA_W-1:0] rd_inst_o,
    output logic [CW-1:0]     count_o
);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [DATA_W-1:0] inst_mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                pc_mem_d[wr_ptr_q]   = wr_pc_i;
                inst_mem_d[wr_ptr_q] = wr_inst_i;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

    assign rd_pc_o   = pc_mem_q[rd_ptr_q];
    assign rd_inst_o = inst_mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/if_fetch_buf.sv
// Fetch buffer between PC/ROM and ID: valid/ready handshake, full stall and flush.
// Optional zero-latency empty bypass is enabled by defining IF_FETCH_BUF_BYPASS_EN.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus,
    parameter int DEPTH  = FetchBufDepth,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    output logic [CW-1:0]     count_o
);

    logic              push;
    logic              pop;
    logic              empty;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_inst;
    logic [CW-1:0]     count;

    if_fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (flush_i),
        .push_i    (push),
        .pop_i     (pop),
        .wr_pc_i   (pc_i),
        .wr_inst_i (inst_i),
        .rd_pc_o   (head_pc),
        .rd_inst_o (head_inst),
        .count_o   (count)
    );

    assign empty       = (count == '0);
    assign stall_req_o = (count == CW'(DEPTH));
    assign count_o     = count;

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        id_valid_o = 1'b0;
        id_pc_o    = ADDR_W'(ZeroWord);
        id_inst_o  = DATA_W'(ZeroWord);
`ifdef IF_FETCH_BUF_BYPASS_EN
        // When empty the incoming pair is offered directly; it is stored only if decode declines it.
        if (empty) begin
            id_valid_o = ce_i & ~flush_i;
            if (id_valid_o) begin
                id_pc_o   = pc_i;
                id_inst_o = inst_i;
            end
            push = ce_i & ~flush_i & ~id_ready_i;
        end else begin
            id_valid_o = 1'b1;
            id_pc_o    = head_pc;
            id_inst_o  = head_inst;
            push       = ce_i & ~stall_req_o & ~flush_i;
            pop        = id_ready_i & ~flush_i;
        end
`else
        id_valid_o = ~empty;
        if (id_valid_o) begin
            id_pc_o   = head_pc;
            id_inst_o = head_inst;
        end
        push = ce_i & ~stall_req_o & ~flush_i;
        pop  = id_valid_o & id_ready_i & ~flush_i;
`endif
    end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf (default build): vector table plus reset/wrap sequences.
module tb_if_fetch_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        flush_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic        stall_req_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        flush;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_stall;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    if_fetch_buf dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .pc_i        (pc_i),
        .inst_i      (inst_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .id_valid_o  (id_valid_o),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o),
        .id_ready_i  (id_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i,
                             input logic s, input logic [2:0] c);
        check_output({tag, ".valid"}, 32'(id_valid_o), 32'(v));
        check_output({tag, ".pc"}, id_pc_o, p);
        check_output({tag, ".inst"}, id_inst_o, i);
        check_output({tag, ".stall"}, 32'(stall_req_o), 32'(s));
        check_output({tag, ".count"}, 32'(count_o), 32'(c));
    endtask

    task automatic apply_stimulus(input logic ce, input logic [31:0] pc, input logic [31:0] inst,
                                  input logic flush, input logic ready);
        ce_i       = ce;
        pc_i       = pc;
        inst_i     = inst;
        flush_i    = flush;
        id_ready_i = ready;
    endtask

    task automatic add_vec(input logic ce, input logic [31:0] pc, input logic [31:0] inst, input logic flush,
                           input logic ready, input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                           input logic es, input logic [2:0] ec);
        vec_t v;
        v.ce = ce; v.pc = pc; v.inst = inst; v.flush = flush; v.ready = ready;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_inst = ei; v.exp_stall = es; v.exp_count = ec;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] IB = 32'h3401_1100;

    initial begin
        // Vectors: inputs for a cycle and the outputs expected during that cycle, before its edge.
        // Streaming with decode always ready.
        add_vec(1, 32'h0, IB+0, 0, 1,  0, 32'h0, 32'h0,  0, 0);
        add_vec(1, 32'h4, IB+1, 0, 1,  1, 32'h0, IB+0,   0, 1);
        add_vec(1, 32'h8, IB+2, 0, 1,  1, 32'h4, IB+1,   0, 1);
        add_vec(1, 32'hC, IB+3, 0, 1,  1, 32'h8, IB+2,   0, 1);
        add_vec(0, 32'h0, 32'h0, 0, 1, 1, 32'hC, IB+3,   0, 1);
        add_vec(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0,  0, 0);
        // Backpressure until full, PC held at 0x10 while stalled.
        add_vec(1, 32'h0,  IB+0, 0, 0, 0, 32'h0, 32'h0,  0, 0);
        add_vec(1, 32'h4,  IB+1, 0, 0, 1, 32'h0, IB+0,   0, 1);
        add_vec(1, 32'h8,  IB+2, 0, 0, 1, 32'h0, IB+0,   0, 2);
        add_vec(1, 32'hC,  IB+3, 0, 0, 1, 32'h0, IB+0,   0, 3);
        add_vec(1, 32'h10, IB+4, 0, 0, 1, 32'h0, IB+0,   1, 4);
        // Full with ready: pop only, then 0x10 accepted while draining.
        add_vec(1, 32'h10, IB+4, 0, 1, 1, 32'h0, IB+0,   1, 4);
        add_vec(1, 32'h10, IB+4, 0, 1, 1, 32'h4, IB+1,   0, 3);
        add_vec(0, 32'h0, 32'h0, 0, 1, 1, 32'h8, IB+2,   0, 3);
        add_vec(0, 32'h0, 32'h0, 0, 1, 1, 32'hC, IB+3,   0, 2);
        add_vec(0, 32'h0, 32'h0, 0, 1, 1, 32'h10, IB+4,  0, 1);
        add_vec(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0,  0, 0);
        // Flush with three entries and a concurrent fetch of 0x20.
        add_vec(1, 32'h40, 32'hA0, 0, 0, 0, 32'h0, 32'h0,  0, 0);
        add_vec(1, 32'h44, 32'hA1, 0, 0, 1, 32'h40, 32'hA0, 0, 1);
        add_vec(1, 32'h48, 32'hA2, 0, 0, 1, 32'h40, 32'hA0, 0, 2);
        add_vec(1, 32'h20, 32'hB0, 1, 1, 1, 32'h40, 32'hA0, 0, 3);
        add_vec(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0,    0, 0);
        add_vec(1, 32'h100, 32'hC0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        add_vec(0, 32'h0, 32'h0, 0, 1, 1, 32'h100, 32'hC0, 0, 1);
        add_vec(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0,    0, 0);
        // Flush while full beats the stall.
        add_vec(1, 32'h200, 32'hD0, 0, 0, 0, 32'h0, 32'h0,   0, 0);
        add_vec(1, 32'h204, 32'hD1, 0, 0, 1, 32'h200, 32'hD0, 0, 1);
        add_vec(1, 32'h208, 32'hD2, 0, 0, 1, 32'h200, 32'hD0, 0, 2);
        add_vec(1, 32'h20C, 32'hD3, 0, 0, 1, 32'h200, 32'hD0, 0, 3);
        add_vec(1, 32'h210, 32'hD4, 1, 0, 1, 32'h200, 32'hD0, 1, 4);
        add_vec(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0,       0, 0);

        // Reset held for three cycles with fetch enabled.
        apply_stimulus(1, 32'h40, 32'h55, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all("reset", 0, 32'h0, 32'h0, 0, 0);
        end
        @(posedge clk);
        #1;
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("idle", 0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].ce, vecs[k].pc, vecs[k].inst, vecs[k].flush, vecs[k].ready);
            @(negedge clk);
            check_all($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_pc, vecs[k].exp_inst,
                      vecs[k].exp_stall, vecs[k].exp_count);
            @(posedge clk);
            #1;
        end

        // Six streamed pairs move both pointers past the wrap point.
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1, 32'h300 + 32'(4*k), 32'hF00 + 32'(k), 0, 1);
            @(negedge clk);
            if (k > 0) begin
                check_output("wrap.pc", id_pc_o, 32'h300 + 32'(4*(k-1)));
                check_output("wrap.inst", id_inst_o, 32'hF00 + 32'(k-1));
            end
            @(posedge clk);
            #1;
        end
        apply_stimulus(0, 32'h0, 32'h0, 0, 1);
        @(negedge clk);
        check_output("wrap.last", id_pc_o, 32'h314);
        @(posedge clk);
        #1;
        apply_stimulus(1, 32'h400, 32'hE0, 0, 0);
        @(posedge clk);
        #1;
        apply_stimulus(1, 32'h404, 32'hE1, 0, 0);
        @(posedge clk);
        #1;
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        check_all("prerst", 1, 32'h400, 32'hE0, 0, 2);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst = 1'b0;
        #1;
        check_all("asyncrst", 0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        apply_stimulus(1, 32'h500, 32'hE5, 0, 0);
        @(posedge clk);
        #1;
        apply_stimulus(1, 32'h504, 32'hE6, 0, 1);
        @(negedge clk);
        check_all("postrst", 1, 32'h500, 32'hE5, 0, 1);
        @(posedge clk);
        #1;
        apply_stimulus(0, 32'h0, 32'h0, 0, 1);
        @(negedge clk);
        check_all("postrst2", 1, 32'h504, 32'hE6, 0, 1);
        @(posedge clk);
        #1;
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        check_all("postrst3", 0, 32'h0, 32'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
